// File: rtl/bus_uart_pkg.sv
// Shared types and constants for the bus-word UART transmitter.
// The serializer uses the state enum; the top uses the frame constants.
package bus_uart_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_e;

   localparam int         FRAME_BYTES       = 5;
   localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

   // Payload byte for frame positions 1..4, most significant byte of the word first.
   function automatic logic [7:0] frame_byte(input logic [31:0] word, input logic [2:0] idx);
      logic [7:0] b;
      case (idx)
         3'd1:    b = word[31:24];
         3'd2:    b = word[23:16];
         3'd3:    b = word[15:8];
         3'd4:    b = word[7:0];
         default: b = 8'h00;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer. A start accepted in the last stop-bit cycle chains the
// next byte with no idle gap; done_o marks that last stop-bit cycle.
module uart_tx_byte
   import bus_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start_i,
   input  logic [7:0] data_i,
   output logic       tx_o,
   output logic       done_o
);

   localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

   state_e      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  shift_q, shift_d;
   logic        tx_q, tx_d;
   logic        bit_end;
   logic        accept;

   assign bit_end = (cnt_q == LAST_CNT);
   assign accept  = start_i && ((state_q == ST_IDLE) || (state_q == ST_STOP && bit_end));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start_i) state_d = ST_START;
         ST_START: if (bit_end) state_d = ST_DATA;
         ST_DATA:  if (bit_end && bit_q == 3'd7) state_d = ST_STOP;
         ST_STOP:  if (bit_end) state_d = start_i ? ST_START : ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      cnt_d   = (state_q == ST_IDLE || bit_end) ? 16'd0 : cnt_q + 16'd1;
      bit_d   = bit_q;
      shift_d = shift_q;
      if (state_q == ST_DATA && bit_end) begin
         bit_d   = bit_q + 3'd1;
         shift_d = shift_q >> 1;
      end
      if (accept) begin
         bit_d   = 3'd0;
         shift_d = data_i;
      end
      // Line level is a function of where we will be next, so it stays registered.
      case (state_d)
         ST_START: tx_d = 1'b0;
         ST_DATA:  tx_d = shift_d[0];
         default:  tx_d = 1'b1;
      endcase
   end

   assign tx_o   = tx_q;
   assign done_o = (state_q == ST_STOP) && bit_end;

endmodule

// File: rtl/bus_uart_tx.sv
// Ships the CPU bus word as a 5-byte UART frame (sync + 4 bytes MSB first)
// whenever it changes or a send is forced; one-deep latest-value buffering.
module bus_uart_tx
   import bus_uart_pkg::*;
#(
   parameter int         CLKS_PER_BIT = 434,
   parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] bus_in,
   input  logic        send,
   output logic        tx,
   output logic        busy,
   output logic [7:0]  lost
);

   logic [31:0] bus_q, bus_prev_q, last_sent_q, last_sent_d, shadow_q, shadow_d;
   logic        send_q, pending_q, pending_d, busy_q, busy_d;
   logic [7:0]  lost_q, lost_d;
   logic [2:0]  idx_q, idx_d;

   logic        chg, evt, last_byte, byte_done, frame_start, next_byte, ser_start;
   logic [7:0]  ser_data;

   assign chg         = (bus_q != last_sent_q) || send_q;
   assign evt         = busy_q && ((bus_q != bus_prev_q) || send_q);
   assign last_byte   = (idx_q == 3'(FRAME_BYTES - 1));
   assign frame_start = chg && (!busy_q || (byte_done && last_byte));
   assign next_byte   = byte_done && !last_byte;
   assign ser_start   = frame_start || next_byte;
   assign ser_data    = frame_start ? SYNC_BYTE : frame_byte(shadow_q, 3'(idx_q + 3'd1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus_q       <= '0;
         bus_prev_q  <= '0;
         send_q      <= 1'b0;
         last_sent_q <= '0;
         shadow_q    <= '0;
         pending_q   <= 1'b0;
         lost_q      <= '0;
         idx_q       <= '0;
         busy_q      <= 1'b0;
      end else begin
         bus_q       <= bus_in;
         bus_prev_q  <= bus_q;
         send_q      <= send;
         last_sent_q <= last_sent_d;
         shadow_q    <= shadow_d;
         pending_q   <= pending_d;
         lost_q      <= lost_d;
         idx_q       <= idx_d;
         busy_q      <= busy_d;
      end
   end

   always_comb begin
      last_sent_d = last_sent_q;
      shadow_d    = shadow_q;
      pending_d   = pending_q;
      lost_d      = lost_q;
      idx_d       = idx_q;
      busy_d      = busy_q;
      if (evt) begin
         pending_d = 1'b1;
         if (pending_q && lost_q != 8'hFF) lost_d = lost_q + 8'd1;
      end
      if (next_byte) idx_d = idx_q + 3'd1;
      if (byte_done && last_byte) busy_d = 1'b0;
      // A new frame takes priority: the value it loads is the one that was pending.
      if (frame_start) begin
         shadow_d    = bus_q;
         last_sent_d = bus_q;
         pending_d   = 1'b0;
         idx_d       = 3'd0;
         busy_d      = 1'b1;
      end
   end

   uart_tx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_ser (
      .clk    (clk),
      .rst_n  (reset),
      .start_i(ser_start),
      .data_i (ser_data),
      .tx_o   (tx),
      .done_o (byte_done)
   );

   assign busy = busy_q;
   assign lost = lost_q;

endmodule

// File: tb/tb_bus_uart_tx.sv
// Directed bench for bus_uart_tx at 4 clocks per bit: samples the line mid-bit
// on falling clock edges and decodes whole frames.
module tb_bus_uart_tx;

   logic        clk;
   logic        reset;
   logic [31:0] bus_in;
   logic        send;
   logic        tx;
   logic        busy;
   logic [7:0]  lost;

   int total = 0;
   int bad   = 0;

   logic [39:0] fr_bytes;
   int          fr_busy;
   logic        fr_busy_after, fr_tx_after;
   logic        fr_ok;
   int          lows;

   bus_uart_tx #(.CLKS_PER_BIT(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus_in(bus_in),
      .send  (send),
      .tx    (tx),
      .busy  (busy),
      .lost  (lost)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Waits (bounded) for a start bit, then records 200 samples plus one after the frame.
   task automatic capture(input int limit, output logic [39:0] bytes, output int busy_cnt,
                          output logic busy_after, output logic tx_after, output logic ok);
      logic [199:0] smp;
      logic [7:0]   b;
      int           w;
      bytes = '0; busy_cnt = 0; busy_after = 1'bx; tx_after = 1'bx; ok = 1'b0;
      smp = '0;
      w = 0;
      while (tx !== 1'b0 && w < limit) begin
         @(negedge clk);
         w++;
      end
      if (tx !== 1'b0) return;
      ok = 1'b1;
      for (int k = 0; k < 200; k++) begin
         if (k > 0) @(negedge clk);
         smp[k] = tx;
         if (busy === 1'b1) busy_cnt++;
      end
      @(negedge clk);
      busy_after = busy;
      tx_after   = tx;
      for (int j = 0; j < 5; j++) begin
         if (smp[40*j + 2] !== 1'b0 || smp[40*j + 38] !== 1'b1) ok = 1'b0;
         for (int i = 0; i < 8; i++) b[i] = smp[40*j + 4*(i+1) + 2];
         bytes = {bytes[31:0], b};
      end
      $display("frame %010h busy_cycles=%0d framing_ok=%0d", bytes, busy_cnt, ok);
   endtask

   task automatic count_low(input int n, output int cnt);
      cnt = 0;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0) cnt++;
      end
   endtask

   initial begin
      reset = 1'b0; bus_in = 32'h0; send = 1'b0;
      repeat (3) @(negedge clk);

      // 1: reset state and quiet bus
      chk("rst_tx", tx, 1);
      chk("rst_busy", busy, 0);
      chk("rst_lost", lost, 0);
      reset = 1'b1;
      count_low(300, lows);
      chk("quiet_after_reset", lows, 0);

      // 2: single change, latency and frame content
      bus_in = 32'h12345678;
      @(negedge clk);
      chk("lat_not_early", tx, 1);
      @(negedge clk);
      chk("lat_fall", tx, 0);
      chk("lat_busy", busy, 1);
      capture(0, fr_bytes, fr_busy, fr_busy_after, fr_tx_after, fr_ok);
      chk("f1_ok", fr_ok, 1);
      chk("f1_bytes", fr_bytes, 40'hA512345678);
      chk("f1_busy_cycles", fr_busy, 200);
      chk("f1_busy_after", fr_busy_after, 0);
      chk("f1_tx_after", fr_tx_after, 1);
      chk("f1_lost", lost, 0);

      // 3: changes during a frame, chained follow-up
      bus_in = 32'h0;
      fork
         capture(10, fr_bytes, fr_busy, fr_busy_after, fr_tx_after, fr_ok);
         begin
            repeat (20) @(negedge clk); bus_in = 32'h1;
            repeat (10) @(negedge clk); bus_in = 32'h2;
            repeat (10) @(negedge clk); bus_in = 32'h3;
         end
      join
      chk("f2_ok", fr_ok, 1);
      chk("f2_bytes", fr_bytes, 40'hA500000000);
      chk("f2_chain_busy", fr_busy_after, 1);
      chk("f2_chain_tx", fr_tx_after, 0);
      capture(0, fr_bytes, fr_busy, fr_busy_after, fr_tx_after, fr_ok);
      chk("f3_ok", fr_ok, 1);
      chk("f3_bytes", fr_bytes, 40'hA500000003);
      chk("f3_busy_cycles", fr_busy, 200);
      chk("f3_busy_after", fr_busy_after, 0);
      chk("f3_lost", lost, 2);
      count_low(100, lows);
      chk("f3_no_extra", lows, 0);

      // 4: forced send of an already-sent value
      bus_in = 32'hDEADBEEF;
      capture(10, fr_bytes, fr_busy, fr_busy_after, fr_tx_after, fr_ok);
      chk("f4_bytes", fr_bytes, 40'hA5DEADBEEF);
      count_low(20, lows);
      chk("f4_idle", lows, 0);
      send = 1'b1;
      @(negedge clk);
      send = 1'b0;
      chk("send_not_early", tx, 1);
      @(negedge clk);
      chk("send_fall", tx, 0);
      capture(0, fr_bytes, fr_busy, fr_busy_after, fr_tx_after, fr_ok);
      chk("f5_ok", fr_ok, 1);
      chk("f5_bytes", fr_bytes, 40'hA5DEADBEEF);
      chk("f5_busy_after", fr_busy_after, 0);
      chk("f5_lost", lost, 2);

      // send together with a change gives exactly one frame
      bus_in = 32'h01020304; send = 1'b1;
      @(negedge clk);
      send = 1'b0;
      capture(10, fr_bytes, fr_busy, fr_busy_after, fr_tx_after, fr_ok);
      chk("f6_bytes", fr_bytes, 40'hA501020304);
      chk("f6_busy_after", fr_busy_after, 0);
      count_low(100, lows);
      chk("f6_single", lows, 0);

      // 5: reset mid-frame, then full re-send
      bus_in = 32'h0F0F0F0F;
      for (int w = 0; w < 10 && tx !== 1'b0; w++) @(negedge clk);
      chk("f7_started", tx, 0);
      repeat (60) @(negedge clk);
      chk("f7_tx_low_before_rst", tx, 0);
      reset = 1'b0;
      #1;
      chk("midrst_tx", tx, 1);
      chk("midrst_busy", busy, 0);
      chk("midrst_lost", lost, 0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      capture(10, fr_bytes, fr_busy, fr_busy_after, fr_tx_after, fr_ok);
      chk("f8_ok", fr_ok, 1);
      chk("f8_bytes", fr_bytes, 40'hA50F0F0F0F);
      chk("f8_busy_after", fr_busy_after, 0);

      // 6: lost counter saturation
      bus_in = 32'h55;
      for (int w = 0; w < 10 && tx !== 1'b0; w++) @(negedge clk);
      chk("f9_started", busy, 1);
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         bus_in = 32'h1000 + i;
      end
      chk("sat_lost", lost, 8'd255);
      for (int w = 0; w < 3000 && busy !== 1'b0; w++) @(negedge clk);
      chk("sat_drained", busy, 0);
      chk("sat_lost_hold", lost, 8'd255);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
